cpu_out_uart: RTL



---
 rtl/cpu_out_uart_if.sv | 26 ++
 rtl/cpu_out_uart.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_out_uart_if.sv
// CPU output bus and serial status bundle for cpu_out_uart.
// The master drives cpu_out; the slave (the UART) drives the rest.
interface cpu_out_uart_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] cpu_out;
  logic                  tx;
  logic                  busy;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output cpu_out,
    input  tx, busy, empty, full, count, overflow
  );

  modport slave (
    input  cpu_out,
    output tx, busy, empty, full, count, overflow
  );
endinterface

// File: rtl/cpu_out_uart.sv
// Captures each change on the CPU out bus into a FIFO and
// ships queued words as start/data(LSB first)/stop serial frames.
module cpu_out_uart #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  cpu_out_uart_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ?
                      $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [DATA_WIDTH-1:0] last_seen;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [NW-1:0]         count_q;
  logic                  overflow_q;
  state_t                state;
  logic [BW-1:0]         baud;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tx_q;

  logic push_req;
  logic full_w;
  logic empty_w;
  logic pop;
  logic push;
  logic baud_done;
  logic bit_last;

  assign push_req  = bus.cpu_out != last_seen;
  assign full_w    = count_q == NW'(DEPTH);
  assign empty_w   = count_q == '0;
  assign pop       = (state == IDLE) && !empty_w;
  // A full FIFO still accepts when the head leaves on the same edge
  assign push      = push_req && (!full_w || pop);
  assign baud_done = baud == BW'(CLKS_PER_BIT - 1);
  assign bit_last  = bit_idx == IW'(DATA_WIDTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seen  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      last_seen <= bus.cpu_out;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_req && !push)
        overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + NW'(1);
        2'b01:   count_q <= count_q - NW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.cpu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          tx_q    <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud  <= '0;
            state <= DATA;
            tx_q  <= shreg[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_last) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = state != IDLE;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule
